hazard_ctrl_unit: RTL

//  Pipeline-control hazard unit for the 5-stage OTTER: load-use and branch-operand RAW stalls, redirect flushes, data-memory wait freeze.

---
 rtl/hazard_ctrl_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: load-use / branch-operand RAW stalls, redirect
// flushes, data-memory wait freeze, and saturating stall/flush counters.
module hazard_ctrl_unit #(
  parameter int unsigned LOAD_LAT = 1,
  parameter bit          BR_IN_ID = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instr,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_mem_read,
  input  logic             redirect,
  input  logic             dmem_busy,
  input  logic             cnt_clr,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Remaining-cycle counter must hold LOAD_LAT+1 (branch after EX load).
  localparam int unsigned REM_W = $clog2(LOAD_LAT + 2);
  localparam logic [REM_W-1:0] LAT_V    = REM_W'(LOAD_LAT);
  localparam logic [REM_W-1:0] LAT_P1_V = REM_W'(LOAD_LAT + 1);
  localparam logic [REM_W-1:0] ONE_V    = REM_W'(1);

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STALL   = 2'd1,
    S_MEMWAIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  state_e             ret_q, ret_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic [6:0]         op;
  logic [4:0]         rs1, rs2;
  logic               use_rs1, use_rs2, is_br;
  logic               ex_match, mem_match;
  logic [REM_W-1:0]   stall_len;
  logic               redir_acc;
  state_e             eff_state;
  logic               unused_instr_bits;

  assign op  = id_instr[6:0];
  assign rs1 = id_instr[19:15];
  assign rs2 = id_instr[24:20];
  assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:7]};

  // Operand usage decode and RAW match against EX/MEM destinations.
  always_comb begin
    use_rs1 = (op == OP_OP) || (op == OP_OPIMM) || (op == OP_LOAD) ||
              (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
    use_rs2 = (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH);
    is_br   = (op == OP_BRANCH) || (op == OP_JALR);
    ex_match  = (ex_rd != 5'd0) &&
                ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
    mem_match = (mem_rd != 5'd0) &&
                ((use_rs1 && (rs1 == mem_rd)) || (use_rs2 && (rs2 == mem_rd)));
  end

  // Stall length: maximum over all applicable hazard terms.
  always_comb begin
    stall_len = '0;
    if (ex_mem_read && ex_match) begin
      stall_len = LAT_V;
    end
    if (BR_IN_ID && is_br) begin
      if (ex_reg_write && !ex_mem_read && ex_match && (stall_len < ONE_V)) begin
        stall_len = ONE_V;
      end
      if (ex_mem_read && ex_match) begin
        stall_len = LAT_P1_V;
      end
      if (mem_mem_read && mem_match && (stall_len < LAT_V)) begin
        stall_len = LAT_V;
      end
    end
  end

  // FSM next state and pipeline control outputs.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    rem_d       = rem_q;
    pc_we       = 1'b1;
    if_id_we    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_hold   = 1'b0;
    redir_acc   = 1'b0;
    eff_state   = (state_q == S_MEMWAIT) ? ret_q : state_q;

    if (rst) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (dmem_busy) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      pipe_hold = 1'b1;
      state_d   = S_MEMWAIT;
      ret_d     = eff_state;
    end else if (redirect) begin
      redir_acc   = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = !BR_IN_ID || (eff_state == S_STALL) || (stall_len != '0);
      state_d     = S_IDLE;
      rem_d       = '0;
    end else if (eff_state == S_STALL) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
      if (rem_q <= ONE_V) begin
        state_d = S_IDLE;
        rem_d   = '0;
      end else begin
        state_d = S_STALL;
        rem_d   = rem_q - ONE_V;
      end
    end else begin
      state_d = S_IDLE;
      if (stall_len != '0) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
        if (stall_len != ONE_V) begin
          state_d = S_STALL;
          rem_d   = stall_len - ONE_V;
        end
      end
    end
  end

  // Saturating profiling counters; clear wins over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_we && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (redir_acc && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      rem_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
